// File: rtl/cayde_decode.sv
// cayde_decode: RV32I decode/operand-fetch stage with busy scoreboard, hazard stall and writeback forwarding.
module cayde_decode #(
    parameter int XLEN   = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid_in,
    output logic            if_ready_out,
    input  logic [31:0]     if_instr_in,
    input  logic [XLEN-1:0] if_pc_in,
    output logic [4:0]      rf_raddr1_out,
    output logic [4:0]      rf_raddr2_out,
    input  logic [XLEN-1:0] rf_rdata1_in,
    input  logic [XLEN-1:0] rf_rdata2_in,
    input  logic            wb_valid_in,
    input  logic [4:0]      wb_rd_in,
    input  logic [XLEN-1:0] wb_wdata_in,
    input  logic            flush_in,
    output logic            ex_valid_out,
    input  logic            ex_ready_in,
    output logic [XLEN-1:0] ex_pc_out,
    output logic [XLEN-1:0] ex_rs1_data_out,
    output logic [XLEN-1:0] ex_rs2_data_out,
    output logic [XLEN-1:0] ex_imm_out,
    output logic [4:0]      ex_rd_out,
    output logic            ex_wen_out,
    output logic [6:0]      ex_opcode_out,
    output logic [2:0]      ex_funct3_out,
    output logic [6:0]      ex_funct7_out,
    output logic            ex_illegal_out
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            wen;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            illegal;
    } bundle_t;

    bundle_t     bundle_q, bundle_d, dec;
    logic        valid_q, valid_d;
    logic [31:0] busy_q, busy_d;
    logic [31:0] ins;
    logic [4:0]  rs1, rs2, rd;
    logic        u_t, j_t, i_t, s_t, b_t, r_t, sys_t;
    logic        use1, use2, fwd1, fwd2, stall, accept;

    always_comb begin
        ins   = if_instr_in;
        rs1   = ins[19:15];
        rs2   = ins[24:20];
        rd    = ins[11:7];
        u_t   = ins[6:0] == OP_LUI || ins[6:0] == OP_AUIPC;
        j_t   = ins[6:0] == OP_JAL;
        i_t   = ins[6:0] == OP_JALR || ins[6:0] == OP_LOAD || ins[6:0] == OP_IMM;
        s_t   = ins[6:0] == OP_STORE;
        b_t   = ins[6:0] == OP_BRANCH;
        r_t   = ins[6:0] == OP_OP;
        sys_t = ins[6:0] == OP_FENCE || ins[6:0] == OP_SYSTEM;
        use1  = i_t || s_t || b_t || r_t;
        use2  = s_t || b_t || r_t;
        fwd1  = FWD_EN && wb_valid_in && wb_rd_in == rs1 && rs1 != 5'd0;
        fwd2  = FWD_EN && wb_valid_in && wb_rd_in == rs2 && rs2 != 5'd0;
        dec.pc       = if_pc_in;
        dec.rs1_data = (!use1 || rs1 == 5'd0) ? '0 : fwd1 ? wb_wdata_in : rf_rdata1_in;
        dec.rs2_data = (!use2 || rs2 == 5'd0) ? '0 : fwd2 ? wb_wdata_in : rf_rdata2_in;
        dec.imm      = u_t ? {ins[31:12], 12'b0} :
                       j_t ? {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0} :
                       s_t ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
                       b_t ? {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0} :
                       (i_t || sys_t) ? {{20{ins[31]}}, ins[31:20]} : '0;
        dec.rd       = rd;
        dec.wen      = (u_t || j_t || i_t || r_t) && rd != 5'd0;
        dec.opcode   = ins[6:0];
        dec.funct3   = ins[14:12];
        dec.funct7   = ins[31:25];
        dec.illegal  = !(u_t || j_t || i_t || s_t || b_t || r_t || sys_t);
        // A same-cycle writeback of the conflicting register resolves the hazard.
        stall = (use1 && rs1 != 5'd0 && busy_q[rs1] && !fwd1) ||
                (use2 && rs2 != 5'd0 && busy_q[rs2] && !fwd2) ||
                (dec.wen && busy_q[rd] && !(wb_valid_in && wb_rd_in == rd));
        if_ready_out = !rst && !flush_in && !stall && (!valid_q || ex_ready_in);
        accept   = if_valid_in && if_ready_out;
        valid_d  = accept ? 1'b1 : (ex_ready_in || flush_in) ? 1'b0 : valid_q;
        bundle_d = accept ? dec : bundle_q;
        busy_d   = busy_q;
        if (wb_valid_in && wb_rd_in != 5'd0)
            busy_d[wb_rd_in] = 1'b0;
        if (flush_in && valid_q && bundle_q.wen)
            busy_d[bundle_q.rd] = 1'b0;
        if (accept && dec.wen)
            busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bundle_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= '0;
        end else begin
            bundle_q <= bundle_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign rf_raddr1_out   = rs1;
    assign rf_raddr2_out   = rs2;
    assign ex_valid_out    = valid_q;
    assign ex_pc_out       = bundle_q.pc;
    assign ex_rs1_data_out = bundle_q.rs1_data;
    assign ex_rs2_data_out = bundle_q.rs2_data;
    assign ex_imm_out      = bundle_q.imm;
    assign ex_rd_out       = bundle_q.rd;
    assign ex_wen_out      = bundle_q.wen;
    assign ex_opcode_out   = bundle_q.opcode;
    assign ex_funct3_out   = bundle_q.funct3;
    assign ex_funct7_out   = bundle_q.funct7;
    assign ex_illegal_out  = bundle_q.illegal;
endmodule
